// File: rtl/top_memoryaccess_pkg.sv
// Shared definitions for the memory-access stage: datapath widths, decoded-op
// field positions, funct3 codes, FSM states and the bus/writeback payload structs.
package top_memoryaccess_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPLEN    = 9;
  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);
  localparam int unsigned BE_W     = 4;
  localparam int unsigned RD_W     = 5;

  // Decoded-op field positions
  localparam int unsigned LOAD_BIT     = 0;
  localparam int unsigned STORE_BIT    = 1;
  localparam int unsigned FUNCT3_BIT_L = 2;
  localparam int unsigned FUNCT3_BIT_M = 4;

  // funct3 size/extension codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } ma_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } dbus_req_t;

  typedef struct packed {
    logic [OPLEN-1:0] decoded_op;
    logic             jump_state;
    logic [RD_W-1:0]  rdsel;
    logic [XLEN-1:0]  next_pc;
    logic [XLEN-1:0]  rd_data;
  } mw_bundle_t;

  // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/top_memoryaccess_mem_align.sv
// Combinational sub-word handling for the data bus.
// Ports:
//   f3_i          funct3 size/extension code
//   addr_lo_i     byte offset within the word
//   is_store_i    1 = store (lane packing), 0 = load (byte enables all on)
//   store_data_i  rs2 store data
//   load_data_i   whole-word read data from the bus
//   be_o          byte enables
//   wdata_o       lane-replicated store data
//   load_ext_o    extracted and extended load result
module top_memoryaccess_mem_align
  import top_memoryaccess_pkg::*;
(
  input  logic [2:0]      f3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] load_data_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store lane packing: data is replicated so any enabled lane carries it
  always_comb begin
    be_o    = 4'hF;
    wdata_o = store_data_i;
    if (is_store_i) begin
      case (f3_i[1:0])
        2'b00: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
          wdata_o = {2{store_data_i[15:0]}};
        end
        default: begin
          be_o    = 4'hF;
          wdata_o = store_data_i;
        end
      endcase
    end
  end

  // Load extraction and extension
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = load_data_i[7:0];
      2'd1:    byte_sel = load_data_i[15:8];
      2'd2:    byte_sel = load_data_i[23:16];
      default: byte_sel = load_data_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? load_data_i[31:16] : load_data_i[15:0];
    case (f3_i)
      F3_B:    load_ext_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_ext_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    load_ext_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   load_ext_o = {{(XLEN-16){1'b0}}, half_sel};
      default: load_ext_o = load_data_i;
    endcase
  end

endmodule

// File: rtl/top_memoryaccess.sv
// Memory-access stage: runs LOAD/STORE over a req/ack data bus, stalls the core
// state machine while the bus is busy, and registers the writeback bundle.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   phase_memoryaccess       MemoryAccess phase from the state machine
//   *_em                     bundle from execute
//   dmem_*                   data-bus request/response
//   stall_memoryaccess       holds the state machine in MemoryAccess (combinational)
//   *_mw                     bundle to writeback
//   mem_fault                one-cycle pulse on misaligned access or bus timeout
module top_memoryaccess
  import top_memoryaccess_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_memoryaccess,
  input  logic [OPLEN-1:0] decoded_op_em,
  input  logic             jump_state_em,
  input  logic [RD_W-1:0]  rdsel_em,
  input  logic [XLEN-1:0]  next_pc_em,
  input  logic [XLEN-1:0]  alu_out_em,
  input  logic [XLEN-1:0]  rs2data_em,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [BE_W-1:0]  dmem_be,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             stall_memoryaccess,
  output logic [OPLEN-1:0] decoded_op_mw,
  output logic             jump_state_mw,
  output logic [RD_W-1:0]  rdsel_mw,
  output logic [XLEN-1:0]  next_pc_mw,
  output logic [XLEN-1:0]  rd_data_mw,
  output logic             mem_fault
);

  ma_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  dbus_req_t       bus_q, bus_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            fault_q, fault_d;
  logic            phase_q;
  mw_bundle_t      mw_q, mw_d;

  logic            is_load, is_store, mem_op, misaligned, aligned_mem, update_mw;
  logic [2:0]      f3;
  logic [BE_W-1:0] align_be;
  logic [XLEN-1:0] align_wdata, load_ext;

  assign is_load     = decoded_op_em[LOAD_BIT];
  assign is_store    = decoded_op_em[STORE_BIT];
  assign mem_op      = is_load | is_store;
  assign f3          = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];
  assign misaligned  = is_misaligned(f3, alu_out_em[1:0]);
  assign aligned_mem = mem_op & ~misaligned;

  assign stall_memoryaccess = phase_memoryaccess & aligned_mem & (state_q != ST_DONE);
  assign update_mw          = phase_memoryaccess & ~stall_memoryaccess;

  top_memoryaccess_mem_align u_align (
    .f3_i         (f3),
    .addr_lo_i    (alu_out_em[1:0]),
    .is_store_i   (is_store),
    .store_data_i (rs2data_em),
    .load_data_i  (dmem_rdata),
    .be_o         (align_be),
    .wdata_o      (align_wdata),
    .load_ext_o   (load_ext)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      bus_q   <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
      phase_q <= 1'b0;
      mw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      bus_q   <= bus_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      phase_q <= phase_memoryaccess;
      mw_q    <= mw_d;
    end
  end

  // Next-state and register-input logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    bus_d   = bus_q;
    data_d  = data_q;
    fault_d = 1'b0;
    mw_d    = mw_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (phase_memoryaccess && aligned_mem) begin
          state_d     = ST_REQ;
          req_d       = 1'b1;
          bus_d.we    = is_store;
          bus_d.addr  = {alu_out_em[XLEN-1:2], 2'b00};
          bus_d.be    = align_be;
          bus_d.wdata = align_wdata;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (dmem_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          cnt_d   = '0;
          data_d  = bus_q.we ? '0 : load_ext;
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          // This is the WAIT_MAX-th ack-free request cycle: abort
          state_d = ST_DONE;
          req_d   = 1'b0;
          cnt_d   = '0;
          data_d  = '0;
          fault_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (!phase_memoryaccess) state_d = ST_IDLE;
      end
    endcase

    // Misaligned access faults once, in the first cycle of the phase
    if (phase_memoryaccess && !phase_q && mem_op && misaligned) fault_d = 1'b1;

    if (update_mw) begin
      mw_d.decoded_op = decoded_op_em;
      mw_d.jump_state = jump_state_em;
      mw_d.rdsel      = rdsel_em;
      mw_d.next_pc    = next_pc_em;
      if (!mem_op)         mw_d.rd_data = alu_out_em;
      else if (misaligned) mw_d.rd_data = '0;
      else                 mw_d.rd_data = data_q;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = bus_q.we;
  assign dmem_addr     = bus_q.addr;
  assign dmem_wdata    = bus_q.wdata;
  assign dmem_be       = bus_q.be;
  assign mem_fault     = fault_q;
  assign decoded_op_mw = mw_q.decoded_op;
  assign jump_state_mw = mw_q.jump_state;
  assign rdsel_mw      = mw_q.rdsel;
  assign next_pc_mw    = mw_q.next_pc;
  assign rd_data_mw    = mw_q.rd_data;

endmodule

// File: tb/tb_top_memoryaccess.sv
// Directed bench for the memory-access stage.
module tb_top_memoryaccess;

  logic        clk, rst, phase_memoryaccess;
  logic [8:0]  decoded_op_em;
  logic        jump_state_em;
  logic [4:0]  rdsel_em;
  logic [31:0] next_pc_em, alu_out_em, rs2data_em;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_memoryaccess;
  logic [8:0]  decoded_op_mw;
  logic        jump_state_mw;
  logic [4:0]  rdsel_mw;
  logic [31:0] next_pc_mw, rd_data_mw;
  logic        mem_fault;

  int n_total = 0;
  int n_bad   = 0;

  // Observations from the last run_op
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [31:0] cap_wdata, cap_addr;
  bit          addr_moved, saw_fault;
  int          n_stall, n_req;

  top_memoryaccess dut (
    .clk                (clk),
    .rst                (rst),
    .phase_memoryaccess (phase_memoryaccess),
    .decoded_op_em      (decoded_op_em),
    .jump_state_em      (jump_state_em),
    .rdsel_em           (rdsel_em),
    .next_pc_em         (next_pc_em),
    .alu_out_em         (alu_out_em),
    .rs2data_em         (rs2data_em),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_be            (dmem_be),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .stall_memoryaccess (stall_memoryaccess),
    .decoded_op_mw      (decoded_op_mw),
    .jump_state_mw      (jump_state_mw),
    .rdsel_mw           (rdsel_mw),
    .next_pc_mw         (next_pc_mw),
    .rd_data_mw         (rd_data_mw),
    .mem_fault          (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] mk_op(input logic ld, input logic st, input logic [2:0] f3);
    return {4'b0000, f3, st, ld};
  endfunction

  // One MemoryAccess phase; ack_after = ack-free request cycles before ack (-1: never)
  task automatic run_op(input logic [8:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int ack_after,
                        input logic [4:0] rd, input logic [31:0] pc);
    bit done;
    done = 1'b0;
    @(negedge clk);
    decoded_op_em = op;  alu_out_em = addr;  rs2data_em = rs2;
    rdsel_em = rd;  next_pc_em = pc;  jump_state_em = 1'b0;
    phase_memoryaccess = 1'b1;  dmem_ack = 1'b0;
    n_stall = 0;  n_req = 0;  saw_fault = 1'b0;  addr_moved = 1'b0;
    cap_be = '0;  cap_we = 1'b0;  cap_wdata = '0;  cap_addr = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_fault) saw_fault = 1'b1;
      if (stall_memoryaccess) n_stall++;
      else done = 1'b1;
      if (dmem_req) begin
        if (n_req == 0) begin
          cap_be = dmem_be;  cap_we = dmem_we;  cap_wdata = dmem_wdata;  cap_addr = dmem_addr;
        end else if (dmem_addr !== cap_addr) begin
          addr_moved = 1'b1;
        end
        if (n_req == ack_after) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
        n_req++;
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      if (done) break;
    end
    if (!done) check_eq("phase_never_finished", 32'(done), 32'd1);
    #1;
    if (mem_fault) saw_fault = 1'b1;
    phase_memoryaccess = 1'b0;
    @(negedge clk);
    #1;
    check_eq("fault_is_pulse", 32'(mem_fault), 32'd0);
  endtask

  localparam logic [8:0] OP_ADD = 9'h100;

  initial begin
    rst = 1'b1;  phase_memoryaccess = 1'b0;  decoded_op_em = '0;  jump_state_em = 1'b0;
    rdsel_em = '0;  next_pc_em = '0;  alu_out_em = '0;  rs2data_em = '0;
    dmem_ack = 1'b0;  dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req",    32'(dmem_req), 32'd0);
    check_eq("rst_rd",     rd_data_mw, 32'd0);
    check_eq("rst_rdsel",  32'(rdsel_mw), 32'd0);
    check_eq("rst_fault",  32'(mem_fault), 32'd0);
    check_eq("rst_stall",  32'(stall_memoryaccess), 32'd0);
    rst = 1'b0;

    // Non-memory op: pass-through
    run_op(OP_ADD, 32'hAAAAAAAA, 32'h0, 32'h0, -1, 5'b10101, 32'h444);
    check_eq("add_rd",    rd_data_mw, 32'hAAAAAAAA);
    check_eq("add_rdsel", 32'(rdsel_mw), 32'h15);
    check_eq("add_pc",    next_pc_mw, 32'h444);
    check_eq("add_op",    32'(decoded_op_mw), 32'h100);
    check_eq("add_req",   32'(n_req), 32'd0);
    check_eq("add_stall", 32'(n_stall), 32'd0);

    // Misaligned SH
    run_op(mk_op(1'b0, 1'b1, 3'b001), 32'h101, 32'h1234, 32'h0, 0, 5'd3, 32'h448);
    check_eq("mis_req",   32'(n_req), 32'd0);
    check_eq("mis_stall", 32'(n_stall), 32'd0);
    check_eq("mis_fault", 32'(saw_fault), 32'd1);
    check_eq("mis_rd",    rd_data_mw, 32'd0);

    // SW, ack in the request cycle
    run_op(mk_op(1'b0, 1'b1, 3'b010), 32'h100, 32'hDEADBEEF, 32'h0, 0, 5'd4, 32'h44C);
    check_eq("sw_be",    32'(cap_be), 32'hF);
    check_eq("sw_wdata", cap_wdata, 32'hDEADBEEF);
    check_eq("sw_we",    32'(cap_we), 32'd1);
    check_eq("sw_addr",  cap_addr, 32'h100);
    check_eq("sw_stall", 32'(n_stall), 32'd2);
    check_eq("sw_req",   32'(n_req), 32'd1);
    check_eq("sw_fault", 32'(saw_fault), 32'd0);

    // SB / SH lane packing
    run_op(mk_op(1'b0, 1'b1, 3'b000), 32'h102, 32'h000000A5, 32'h0, 0, 5'd5, 32'h450);
    check_eq("sb_be",    32'(cap_be), 32'h4);
    check_eq("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    run_op(mk_op(1'b0, 1'b1, 3'b001), 32'h102, 32'h1234BEEF, 32'h0, 0, 5'd5, 32'h454);
    check_eq("sh_be",    32'(cap_be), 32'hC);
    check_eq("sh_wdata", cap_wdata, 32'hBEEFBEEF);

    // Byte and half loads with sign/zero extension
    run_op(mk_op(1'b1, 1'b0, 3'b000), 32'h103, 32'h0, 32'h80123456, 0, 5'd6, 32'h458);
    check_eq("lb_rd",   rd_data_mw, 32'hFFFFFF80);
    check_eq("lb_be",   32'(cap_be), 32'hF);
    check_eq("lb_we",   32'(cap_we), 32'd0);
    check_eq("lb_addr", cap_addr, 32'h100);
    run_op(mk_op(1'b1, 1'b0, 3'b100), 32'h103, 32'h0, 32'h80123456, 0, 5'd6, 32'h45C);
    check_eq("lbu_rd",  rd_data_mw, 32'h00000080);
    run_op(mk_op(1'b1, 1'b0, 3'b001), 32'h102, 32'h0, 32'h80015555, 0, 5'd7, 32'h460);
    check_eq("lh_rd",   rd_data_mw, 32'hFFFF8001);
    run_op(mk_op(1'b1, 1'b0, 3'b101), 32'h102, 32'h0, 32'h80015555, 0, 5'd7, 32'h464);
    check_eq("lhu_rd",  rd_data_mw, 32'h00008001);

    // LW with three ack-free cycles
    run_op(mk_op(1'b1, 1'b0, 3'b010), 32'h200, 32'h0, 32'h12345678, 3, 5'd8, 32'h468);
    check_eq("lw_req",   32'(n_req), 32'd4);
    check_eq("lw_stall", 32'(n_stall), 32'd5);
    check_eq("lw_moved", 32'(addr_moved), 32'd0);
    check_eq("lw_addr",  cap_addr, 32'h200);
    check_eq("lw_rd",    rd_data_mw, 32'h12345678);

    // LW with no ack: bus timeout
    run_op(mk_op(1'b1, 1'b0, 3'b010), 32'h204, 32'h0, 32'h0, -1, 5'd9, 32'h46C);
    check_eq("to_req",   32'(n_req), 32'd15);
    check_eq("to_fault", 32'(saw_fault), 32'd1);
    check_eq("to_rd",    rd_data_mw, 32'd0);
    check_eq("to_rdsel", 32'(rdsel_mw), 32'd9);

    // Reset in the middle of WAIT
    @(negedge clk);
    decoded_op_em = mk_op(1'b1, 1'b0, 3'b010);  alu_out_em = 32'h300;
    rdsel_em = 5'd10;  next_pc_em = 32'h470;  phase_memoryaccess = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req",   32'(dmem_req), 32'd0);
    check_eq("mid_rst_op",    32'(decoded_op_mw), 32'd0);
    check_eq("mid_rst_rdsel", 32'(rdsel_mw), 32'd0);
    check_eq("mid_rst_pc",    next_pc_mw, 32'd0);
    check_eq("mid_rst_rd",    rd_data_mw, 32'd0);
    @(negedge clk);
    rst = 1'b0;  phase_memoryaccess = 1'b0;
    run_op(mk_op(1'b1, 1'b0, 3'b010), 32'h300, 32'h0, 32'hCAFEF00D, 0, 5'd10, 32'h474);
    check_eq("post_rst_rd",  rd_data_mw, 32'hCAFEF00D);
    check_eq("post_rst_req", 32'(n_req), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
